// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the fetch side of the pipeline.
//   - fetch_state_e : outstanding-request tracker used by the IF-ID register
//                     (IDLE = nothing in flight, WAIT = live request in flight,
//                     KILL = flushed request still in flight).
//   - XLEN_DEFAULT  : default datapath width (PC, address, instruction).
//   - CNT_W_DEFAULT : default width of performance counters.
//   - CLEAR_INST_DEFAULT : instruction word presented to ID for a bubble.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 32;

  // Bubble instruction. All-zeros decodes as an illegal/no-effect word in
  // this core's decoder, and valid_d=0 accompanies it anyway.
  localparam logic [31:0] CLEAR_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_seg_reg_vl.sv
// ---------------------------------------------------------------------------
// if_id_seg_reg_vl
//   IF-ID segment register for an instruction source with variable latency
//   (cache or BRAM wrapper). Captures the IF PC, keeps exactly one fetch
//   request outstanding on a level req / single-cycle ack handshake, and
//   forwards the returned instruction to ID combinationally in the ack cycle,
//   so a first-cycle ack behaves exactly like a one-cycle BRAM.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   en             stage enable (0 = stall, hold state)
//   clear          flush, honoured only when en=1
//   pc_f           PC from IF
//   pc_d           registered PC for ID
//   inst_d         instruction for ID
//   valid_d        inst_d carries a real instruction
//   fetch_stall    request pending without response; hazard unit must stall
//   imem_req       fetch request, held until ack
//   imem_addr      fetch address, stable while imem_req=1
//   imem_rdata     fetch data, valid with imem_ack
//   imem_ack       one-cycle response strobe
//   perf_wait_cnt  saturating count of cycles spent with fetch_stall=1
// ---------------------------------------------------------------------------
module if_id_seg_reg_vl
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] CLEAR_INST = XLEN'(CLEAR_INST_DEFAULT),
  parameter int unsigned     CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [XLEN-1:0]  pc_f,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  inst_d,
  output logic             valid_d,
  output logic             fetch_stall,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_ack,
  output logic [CNT_W-1:0] perf_wait_cnt
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fetch_state_e     state_q,      state_d;
  logic [XLEN-1:0]  id_pc_q,      id_pc_d;       // PC presented to ID
  logic [XLEN-1:0]  addr_q,       addr_d;        // address of request in flight
  logic [XLEN-1:0]  hold_q,       hold_d;        // instruction parked for ID
  logic             hold_valid_q, hold_valid_d;  // hold_q is a real instruction
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;

  // -------------------------------------------------------------------------
  // Handshake status
  // -------------------------------------------------------------------------
  logic req_live;
  logic stall_now;
  logic flush;
  logic advance;
  logic live_ack;
  logic dead_ack;

  always_comb begin
    req_live  = (state_q != IDLE);
    stall_now = req_live && !imem_ack;
    // A flush is honoured even if the hazard unit wrongly left en=1 during a
    // stall; a normal advance is not (fetch_stall forces an implicit hold).
    flush     = en && clear;
    advance   = en && !clear && ((state_q == IDLE) || imem_ack);
    // Acks only mean something while a request is outstanding; an ack in
    // IDLE is spurious and falls through every branch below untouched.
    live_ack  = (state_q == WAIT) && imem_ack;
    dead_ack  = (state_q == KILL) && imem_ack;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    id_pc_d      = id_pc_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (flush) begin
      id_pc_d      = '0;
      hold_d       = CLEAR_INST;
      hold_valid_d = 1'b0;
      // An unanswered request cannot be withdrawn, so it is tracked as KILL
      // until its ack arrives and the returned word is thrown away.
      case (state_q)
        WAIT:    state_d = imem_ack ? IDLE : KILL;
        KILL:    state_d = imem_ack ? IDLE : KILL;
        default: state_d = IDLE;
      endcase
    end else begin
      if (live_ack) begin
        // Park the returned word; if the stage is stalled ID keeps seeing it
        // from hold_q once the state drops back to IDLE.
        hold_d       = imem_rdata;
        hold_valid_d = 1'b1;
        state_d      = IDLE;
      end
      if (dead_ack) begin
        state_d = IDLE;
      end
      // Capture the next PC and issue its request in the same edge; this is
      // what lets back-to-back first-cycle acks sustain one instruction per
      // cycle and lets a new request follow a killed one without a gap.
      if (advance) begin
        id_pc_d = pc_f;
        addr_d  = pc_f;
        state_d = WAIT;
      end
    end
  end

  // Miss-wait counter: counts every edge that sees fetch_stall, stops at
  // all-ones instead of wrapping so long runs never read as short ones.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (stall_now && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      id_pc_q      <= '0;
      addr_q       <= '0;
      hold_q       <= CLEAR_INST;
      hold_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      id_pc_q      <= id_pc_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req      = req_live;
    fetch_stall   = stall_now;
    imem_addr     = addr_q;
    pc_d          = id_pc_q;
    perf_wait_cnt = wait_cnt_q;

    case (state_q)
      WAIT: begin
        // Bypass the response straight to ID in the ack cycle; otherwise
        // ID sees a bubble while the miss is outstanding.
        inst_d  = imem_ack ? imem_rdata : CLEAR_INST;
        valid_d = imem_ack;
      end
      KILL: begin
        inst_d  = CLEAR_INST;
        valid_d = 1'b0;
      end
      default: begin
        inst_d  = hold_q;
        valid_d = hold_valid_q;
      end
    endcase
  end

endmodule

// File: tb/tb_if_id_seg_reg_vl.sv
// ---------------------------------------------------------------------------
// tb_if_id_seg_reg_vl
//   Directed bench for if_id_seg_reg_vl. Two instances share all inputs: one
//   with the default 32-bit wait counter and one with a 3-bit counter to
//   exercise saturation. Inputs change 1 time unit after the rising edge and
//   outputs are checked 2 units later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_if_id_seg_reg_vl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clear;
  logic [31:0] pc_f;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  logic [31:0] pc_d, inst_d, imem_addr, perf_wait_cnt;
  logic        valid_d, fetch_stall, imem_req;

  logic [31:0] pc_d3, inst_d3, imem_addr3;
  logic        valid_d3, fetch_stall3, imem_req3;
  logic [2:0]  perf_wait_cnt3;

  int checks = 0;
  int passed = 0;

  if_id_seg_reg_vl #(.XLEN(32), .CLEAR_INST(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pc_f(pc_f),
    .pc_d(pc_d), .inst_d(inst_d), .valid_d(valid_d), .fetch_stall(fetch_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .perf_wait_cnt(perf_wait_cnt)
  );

  if_id_seg_reg_vl #(.XLEN(32), .CLEAR_INST(32'h0000_0000), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pc_f(pc_f),
    .pc_d(pc_d3), .inst_d(inst_d3), .valid_d(valid_d3), .fetch_stall(fetch_stall3),
    .imem_req(imem_req3), .imem_addr(imem_addr3), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .perf_wait_cnt(perf_wait_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [31:0] pc,
                       input logic ack, input logic [31:0] rdata);
    en = e; clear = c; pc_f = pc; imem_ack = ack; imem_rdata = rdata;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0; clear = 1'b0; pc_f = '0; imem_ack = 1'b0; imem_rdata = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1; clear = 1'b0; pc_f = 32'h0000_0abc; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    tick();
    #2;
    checks++; if (pc_d !== 32'h0) $display("FAIL rst_pc_d got=%h exp=%h", pc_d, 32'h0); else passed++;
    checks++; if (inst_d !== 32'h0) $display("FAIL rst_inst_d got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL rst_valid_d got=%b exp=0", valid_d); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req got=%b exp=0", imem_req); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("FAIL rst_fetch_stall got=%b exp=0", fetch_stall); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rst_imem_addr got=%h exp=%h", imem_addr, 32'h0); else passed++;
    checks++; if (perf_wait_cnt !== 32'h0) $display("FAIL rst_perf got=%0d exp=0", perf_wait_cnt); else passed++;
    checks++; if (perf_wait_cnt3 !== 3'd0) $display("FAIL rst_perf3 got=%0d exp=0", perf_wait_cnt3); else passed++;
    checks++; if (pc_d3 !== 32'h0) $display("FAIL rst_pc_d3 got=%h exp=%h", pc_d3, 32'h0); else passed++;
    $display("reset: pc_d=%h inst_d=%h valid_d=%b imem_req=%b", pc_d, inst_d, valid_d, imem_req);
    rst = 1'b1;
  endtask

  // Hit at 0x100, back-to-back hit at 0x104, which is left stalled in ID.
  task automatic test_hit_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b0) $display("FAIL hit_idle_req got=%b exp=0", imem_req); else passed++;
    tick();
    // First request cycle: memory answers immediately; next PC offered.
    drive(1'b1, 1'b0, 32'h0000_0104, 1'b1, 32'h0050_0093);
    checks++; if (pc_d !== 32'h100) $display("FAIL hit_pc_d got=%h exp=%h", pc_d, 32'h100); else passed++;
    checks++; if (inst_d !== 32'h0050_0093) $display("FAIL hit_inst_d got=%h exp=%h", inst_d, 32'h0050_0093); else passed++;
    checks++; if (valid_d !== 1'b1) $display("FAIL hit_valid_d got=%b exp=1", valid_d); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("FAIL hit_fetch_stall got=%b exp=0", fetch_stall); else passed++;
    checks++; if (imem_addr !== 32'h100) $display("FAIL hit_addr got=%h exp=%h", imem_addr, 32'h100); else passed++;
    checks++; if (perf_wait_cnt !== 32'd0) $display("FAIL hit_perf got=%0d exp=0", perf_wait_cnt); else passed++;
    $display("hit: pc_d=%h inst_d=%h valid_d=%b", pc_d, inst_d, valid_d);
    tick();
    // Back-to-back: request 0x104 issued in the previous ack cycle, hits now.
    drive(1'b0, 1'b0, 32'h0000_0108, 1'b1, 32'h0020_8233);
    checks++; if (pc_d !== 32'h104) $display("FAIL b2b_pc_d got=%h exp=%h", pc_d, 32'h104); else passed++;
    checks++; if (imem_addr !== 32'h104) $display("FAIL b2b_addr got=%h exp=%h", imem_addr, 32'h104); else passed++;
    checks++; if (inst_d !== 32'h0020_8233) $display("FAIL b2b_inst_d got=%h exp=%h", inst_d, 32'h0020_8233); else passed++;
    checks++; if (valid_d !== 1'b1) $display("FAIL b2b_valid_d got=%b exp=1", valid_d); else passed++;
    $display("back_to_back: pc_d=%h inst_d=%h valid_d=%b", pc_d, inst_d, valid_d);
    tick();
  endtask

  // Continues from test_hit_back_to_back: 0x104 parked, stage stalled.
  task automatic test_stall_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0999, 1'b0, 32'hFFFF_FFFF);
      checks++; if (pc_d !== 32'h104) $display("FAIL hold%0d_pc_d got=%h exp=%h", i, pc_d, 32'h104); else passed++;
      checks++; if (inst_d !== 32'h0020_8233) $display("FAIL hold%0d_inst_d got=%h exp=%h", i, inst_d, 32'h0020_8233); else passed++;
      checks++; if (valid_d !== 1'b1) $display("FAIL hold%0d_valid got=%b exp=1", i, valid_d); else passed++;
      checks++; if (imem_req !== 1'b0) $display("FAIL hold%0d_req got=%b exp=0", i, imem_req); else passed++;
      $display("stall_hold %0d: pc_d=%h inst_d=%h valid_d=%b", i, pc_d, inst_d, valid_d);
      tick();
    end
  endtask

  // Three-cycle miss at 0x200; en left high during the stall is ignored.
  task automatic test_miss();
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0000_0204, 1'b0, 32'hDEAD_0000);
      checks++; if (fetch_stall !== 1'b1) $display("FAIL miss%0d_stall got=%b exp=1", i, fetch_stall); else passed++;
      checks++; if (imem_addr !== 32'h200) $display("FAIL miss%0d_addr got=%h exp=%h", i, imem_addr, 32'h200); else passed++;
      checks++; if (pc_d !== 32'h200) $display("FAIL miss%0d_pc_d got=%h exp=%h", i, pc_d, 32'h200); else passed++;
      checks++; if (valid_d !== 1'b0) $display("FAIL miss%0d_valid got=%b exp=0", i, valid_d); else passed++;
      checks++; if (perf_wait_cnt !== 32'(i)) $display("FAIL miss%0d_perf got=%0d exp=%0d", i, perf_wait_cnt, i); else passed++;
      $display("miss wait %0d: stall=%b addr=%h perf=%0d", i, fetch_stall, imem_addr, perf_wait_cnt);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0000_0204, 1'b1, 32'h00A0_0113);
    checks++; if (fetch_stall !== 1'b0) $display("FAIL miss_ack_stall got=%b exp=0", fetch_stall); else passed++;
    checks++; if (inst_d !== 32'h00A0_0113) $display("FAIL miss_ack_inst got=%h exp=%h", inst_d, 32'h00A0_0113); else passed++;
    checks++; if (perf_wait_cnt !== 32'd3) $display("FAIL miss_perf got=%0d exp=3", perf_wait_cnt); else passed++;
    checks++; if (perf_wait_cnt3 !== 3'd3) $display("FAIL miss_perf3 got=%0d exp=3", perf_wait_cnt3); else passed++;
    $display("miss ack: inst_d=%h perf=%0d", inst_d, perf_wait_cnt);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0);
    checks++; if (inst_d !== 32'h00A0_0113) $display("FAIL miss_held_inst got=%h exp=%h", inst_d, 32'h00A0_0113); else passed++;
    checks++; if (valid_d !== 1'b1) $display("FAIL miss_held_valid got=%b exp=1", valid_d); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL miss_held_req got=%b exp=0", imem_req); else passed++;
    checks++; if (perf_wait_cnt !== 32'd3) $display("FAIL miss_held_perf got=%0d exp=3", perf_wait_cnt); else passed++;
    $display("miss held: inst_d=%h valid_d=%b perf=%0d", inst_d, valid_d, perf_wait_cnt);
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0300, 1'b0, 32'h0);
    tick();
    // Flush while 0x300 is outstanding without ack -> KILL.
    drive(1'b1, 1'b1, 32'h0000_0304, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0304, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1) $display("FAIL kill_req got=%b exp=1", imem_req); else passed++;
    checks++; if (fetch_stall !== 1'b1) $display("FAIL kill_stall got=%b exp=1", fetch_stall); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL kill_valid got=%b exp=0", valid_d); else passed++;
    checks++; if (inst_d !== 32'h0) $display("FAIL kill_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (pc_d !== 32'h0) $display("FAIL kill_pc_d got=%h exp=%h", pc_d, 32'h0); else passed++;
    checks++; if (imem_addr !== 32'h300) $display("FAIL kill_addr got=%h exp=%h", imem_addr, 32'h300); else passed++;
    $display("flush kill: req=%b valid_d=%b inst_d=%h", imem_req, valid_d, inst_d);
    tick();
    // Late ack for the killed request; new request 0x400 issues this edge.
    drive(1'b1, 1'b0, 32'h0000_0400, 1'b1, 32'hDEAD_BEEF);
    checks++; if (inst_d !== 32'h0) $display("FAIL kill_ack_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL kill_ack_valid got=%b exp=0", valid_d); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("FAIL kill_ack_stall got=%b exp=0", fetch_stall); else passed++;
    $display("flush late ack: inst_d=%h valid_d=%b", inst_d, valid_d);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0404, 1'b0, 32'hDEAD_BEEF);
    checks++; if (pc_d !== 32'h400) $display("FAIL reissue_pc_d got=%h exp=%h", pc_d, 32'h400); else passed++;
    checks++; if (imem_addr !== 32'h400) $display("FAIL reissue_addr got=%h exp=%h", imem_addr, 32'h400); else passed++;
    checks++; if (imem_req !== 1'b1) $display("FAIL reissue_req got=%b exp=1", imem_req); else passed++;
    checks++; if (inst_d !== 32'h0) $display("FAIL reissue_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'h0000_0404, 1'b1, 32'h0000_0013);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0404, 1'b0, 32'h0);
    checks++; if (inst_d !== 32'h0000_0013) $display("FAIL reissue_held_inst got=%h exp=%h", inst_d, 32'h0000_0013); else passed++;
    $display("flush reissue: pc_d=%h inst_d=%h", pc_d, inst_d);
    // Flush coinciding with the ack of a live request: data dropped, IDLE.
    drive(1'b1, 1'b0, 32'h0000_0500, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0504, 1'b1, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0504, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b0) $display("FAIL flush_ack_req got=%b exp=0", imem_req); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL flush_ack_valid got=%b exp=0", valid_d); else passed++;
    checks++; if (inst_d !== 32'h0) $display("FAIL flush_ack_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (pc_d !== 32'h0) $display("FAIL flush_ack_pc_d got=%h exp=%h", pc_d, 32'h0); else passed++;
    $display("flush with ack: req=%b valid_d=%b inst_d=%h", imem_req, valid_d, inst_d);
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0600, 1'b0, 32'h0);
    tick();
    en = 1'b0;
    #2;
    rst = 1'b0;   // between edges
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL arst_req got=%b exp=0", imem_req); else passed++;
    checks++; if (pc_d !== 32'h0) $display("FAIL arst_pc_d got=%h exp=%h", pc_d, 32'h0); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL arst_valid got=%b exp=0", valid_d); else passed++;
    checks++; if (inst_d !== 32'h0) $display("FAIL arst_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("FAIL arst_stall got=%b exp=0", fetch_stall); else passed++;
    $display("async reset: req=%b pc_d=%h valid_d=%b", imem_req, pc_d, valid_d);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0000_0604, 1'b1, 32'h0BAD_0BAD);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0604, 1'b0, 32'h0);
    checks++; if (inst_d !== 32'h0) $display("FAIL stray_inst got=%h exp=%h", inst_d, 32'h0); else passed++;
    checks++; if (valid_d !== 1'b0) $display("FAIL stray_valid got=%b exp=0", valid_d); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL stray_req got=%b exp=0", imem_req); else passed++;
    $display("stray ack after reset: inst_d=%h valid_d=%b", inst_d, valid_d);
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_0700, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0000_0704, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0000_0704, 1'b1, 32'h0030_0193);
    checks++; if (perf_wait_cnt3 !== 3'd7) $display("FAIL sat_perf3 got=%0d exp=7", perf_wait_cnt3); else passed++;
    checks++; if (perf_wait_cnt !== 32'd10) $display("FAIL sat_perf32 got=%0d exp=10", perf_wait_cnt); else passed++;
    $display("saturation: perf3=%0d perf32=%0d", perf_wait_cnt3, perf_wait_cnt);
    tick();
    // Spurious ack in IDLE with different data.
    drive(1'b0, 1'b0, 32'h0000_0704, 1'b1, 32'h0BAD_0BAD);
    checks++; if (inst_d !== 32'h0030_0193) $display("FAIL spur_inst got=%h exp=%h", inst_d, 32'h0030_0193); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL spur_req got=%b exp=0", imem_req); else passed++;
    checks++; if (fetch_stall !== 1'b0) $display("FAIL spur_stall got=%b exp=0", fetch_stall); else passed++;
    tick();
    drive(1'b0, 1'b0, 32'h0000_0704, 1'b0, 32'h0);
    checks++; if (inst_d !== 32'h0030_0193) $display("FAIL spur_after_inst got=%h exp=%h", inst_d, 32'h0030_0193); else passed++;
    checks++; if (valid_d !== 1'b1) $display("FAIL spur_after_valid got=%b exp=1", valid_d); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL spur_after_req got=%b exp=0", imem_req); else passed++;
    checks++; if (perf_wait_cnt3 !== 3'd7) $display("FAIL spur_perf3 got=%0d exp=7", perf_wait_cnt3); else passed++;
    checks++; if (perf_wait_cnt !== 32'd10) $display("FAIL spur_perf32 got=%0d exp=10", perf_wait_cnt); else passed++;
    $display("spurious ack: inst_d=%h perf3=%0d", inst_d, perf_wait_cnt3);
    tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; pc_f = '0; imem_ack = 1'b0; imem_rdata = '0;
    #1;
    test_reset();
    test_hit_back_to_back();
    test_stall_hold();
    test_miss();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
